seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. Successor to the single-digit combinational hex decoder.
- Latches an N-nibble value on a load strobe. Scans one digit per slot, with a guard gap between digits to suppress ghosting. Registers all segment, anode and dp outputs.
- Sits between the random-number core and the board display pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_scan_driver_if.sv | 15 +
 rtl/seg7_prescaler.sv | 68 ++++++
 rtl/seg7_scan_driver.sv | 125 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 7-segment driver:
// the active-low glyph table, the blank pattern and the prescaler state type.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digit index width; eight digits is the widest supported display.
  localparam int IDX_W = 3;

  // {a,b,c,d,e,f,g}, a = MSB, 0 = segment lit.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic {
    PS_START,
    PS_RUN
  } pre_state_e;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data/display bundle between the value source and the 7-segment scan driver.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (output value, load, dp_mask, input seg, dp, an, frame_start);
  modport slave  (input value, load, dp_mask, output seg, dp, an, frame_start);
endinterface

// File: rtl/seg7_prescaler.sv
// Slot timer and digit index for the scan driver; flags slot boundaries one
// edge ahead so the top can register its outputs on the boundary edge.
//
//   state    | meaning
//   PS_START | held in reset; the next edge opens digit 0's slot
//   PS_RUN   | counting 0..SCAN_DIV-1 within a slot, stepping the digit on wrap
module seg7_prescaler
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             wrap,
  output logic             active_next,
  output logic [IDX_W-1:0] idx_next,
  output logic             frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  pre_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PS_START;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_next;
      frame_start <= wrap && (idx_next == '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    wrap     = 1'b0;
    cnt_d    = cnt_q;
    idx_next = idx_q;
    case (state_q)
      PS_START: begin
        state_d  = PS_RUN;
        wrap     = 1'b1;
        cnt_d    = '0;
        idx_next = '0;
      end
      PS_RUN: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          wrap     = 1'b1;
          cnt_d    = '0;
          idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = PS_START;
    endcase
    active_next = (cnt_d >= CNT_W'(GUARD));
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with registered outputs.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg7_scan_driver: NUM_DIGITS must be 1..8");
    end
    if (SCAN_DIV <= GUARD || GUARD < 0) begin : g_bad_timing
      $error("seg7_scan_driver: SCAN_DIV must exceed GUARD");
    end
  endgenerate

  logic                    wrap, active_next, frame_start;
  logic [IDX_W-1:0]        idx_next;
  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [3:0]              nib_sel;
  logic                    dp_sel;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic [NUM_DIGITS-1:0]   an_q;

  seg7_prescaler #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .GUARD      (GUARD)
  ) u_prescaler (
    .clk         (clk),
    .rst         (rst),
    .wrap        (wrap),
    .active_next (active_next),
    .idx_next    (idx_next),
    .frame_start (frame_start)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_run;
  logic                  blank_sel;

  // Walk down from the top digit; a digit is blankable while every nibble
  // from it upward is zero. Digit 0 always shows.
  always_comb begin
    lead_zero = '0;
    zero_run  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (shadow_val[4*i +: 4] == 4'h0);
      lead_zero[i] = zero_run;
    end
    lead_zero[0] = 1'b0;
  end
`endif

  always_comb begin
    nib_sel = '0;
    dp_sel  = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank_sel = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nib_sel = shadow_val[4*i +: 4];
        dp_sel  = shadow_dp[i];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        blank_sel = lead_zero[i];
`endif
      end
    end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    glyph = blank_sel ? SEG_BLANK : hex_to_seg(nib_sel);
`else
    glyph = hex_to_seg(nib_sel);
`endif
  end

  always_comb begin
    an_next = '1;
    if (active_next) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_next == IDX_W'(i)) an_next[i] = 1'b0;
      end
    end
  end

  // Glyph and dp are sampled only on the boundary edge, so a load never
  // tears the slot in progress; a load on that same edge lands a slot later.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      an_q       <= '1;
    end else begin
      if (bus.load) begin
        shadow_val <= bus.value;
        shadow_dp  <= bus.dp_mask;
      end
      if (wrap) begin
        seg_q <= glyph;
        dp_q  <= ~dp_sel;
      end
      an_q <= an_next;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.frame_start = frame_start;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at 4 digits, 8-cycle slots, 2-cycle guard.
// Expectations follow SEG7_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int GD = 2;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h01;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  seg7_scan_driver_if #(.NUM_DIGITS(ND)) bus();

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .GUARD      (GD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] m);
    bus.value   = v;
    bus.dp_mask = m;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (bus.frame_start !== 1'b1 && k < 64);
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_start=%b after %0d cycles, required 1", bus.frame_start, k);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.load    = 1'b0;
    bus.value   = '0;
    bus.dp_mask = '0;
    tick(3);
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7f", bus.seg); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want f", bus.an); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", bus.dp); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", bus.frame_start); end
    rst = 1'b0;
    tick();
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL release_fs: got %b want 1", bus.frame_start); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL release_an_guard: got %h want f", bus.an); end
    checks++; if (bus.seg !== 7'h01) begin errors++; $display("FAIL release_seg: got %h want 01", bus.seg); end
    tick();
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL release_fs_pulse: got %b want 0", bus.frame_start); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL release_an_guard2: got %h want f", bus.an); end
    tick();
    checks++; if (bus.an !== 4'hE) begin errors++; $display("FAIL release_an_on: got %h want e", bus.an); end
    checks++; if (bus.seg !== 7'h01) begin errors++; $display("FAIL release_seg_on: got %h want 01", bus.seg); end
  endtask

  // Loads v/m, then walks one full frame checking every cycle.
  task automatic test_scan(input logic [15:0] v, input logic [3:0] m, input logic [3:0][6:0] exp_seg);
    int         d, p;
    logic [3:0] exp_an;
    logic       exp_fs, exp_dp;
    do_load(v, m);
    wait_frame();
    for (int c = 0; c < 4 * SD; c++) begin
      d      = c / SD;
      p      = c % SD;
      exp_an = (p < GD) ? 4'hF : ~(4'b0001 << d);
      exp_fs = (c == 0);
      exp_dp = ~m[d];
      checks++; if (bus.an !== exp_an) begin errors++; $display("FAIL scan_an v=%h c=%0d: got %h want %h", v, c, bus.an, exp_an); end
      checks++; if (bus.seg !== exp_seg[d]) begin errors++; $display("FAIL scan_seg v=%h c=%0d: got %h want %h", v, c, bus.seg, exp_seg[d]); end
      checks++; if (bus.dp !== exp_dp) begin errors++; $display("FAIL scan_dp v=%h c=%0d: got %b want %b", v, c, bus.dp, exp_dp); end
      checks++; if (bus.frame_start !== exp_fs) begin errors++; $display("FAIL scan_fs v=%h c=%0d: got %b want %b", v, c, bus.frame_start, exp_fs); end
      tick();
    end
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL scan_period v=%h: fs=%b want 1 after 32 cycles", v, bus.frame_start); end
  endtask

  // Entered at cycle 0 of digit 0 with shadow 1A2F / dp 0100.
  task automatic test_load_on_wrap();
    tick(3 * SD + SD - 1);
    checks++; if (bus.an !== 4'h7) begin errors++; $display("FAIL wrap_pos: an=%h want 7", bus.an); end
    do_load(16'h0005, 4'b0000);
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL wrap_fs: got %b want 1", bus.frame_start); end
    checks++; if (bus.seg !== 7'h38) begin errors++; $display("FAIL wrap_old_seg: got %h want 38", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL wrap_old_dp: got %b want 1", bus.dp); end
    tick(SD);
    checks++; if (bus.seg !== LZ) begin errors++; $display("FAIL wrap_new_seg: got %h want %h", bus.seg, LZ); end
  endtask

  // Entered at cycle 0 of digit 1; two loads just before the next boundary.
  task automatic test_back_to_back();
    tick(5);
    do_load(16'h0700, 4'b0000);
    do_load(16'h0B00, 4'b0000);
    tick();
    checks++; if (bus.seg !== 7'h60) begin errors++; $display("FAIL b2b_seg: got %h want 60", bus.seg); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL b2b_an_guard: got %h want f", bus.an); end
  endtask

  // Entered at cycle 0 of digit 2; reset lands at prescaler 5 with a load.
  task automatic test_reset_mid_slot();
    tick(5);
    checks++; if (bus.an !== 4'hB) begin errors++; $display("FAIL mid_pos: an=%h want b", bus.an); end
    rst         = 1'b1;
    bus.value   = 16'hFFFF;
    bus.dp_mask = 4'hF;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL mid_rst_seg: got %h want 7f", bus.seg); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL mid_rst_an: got %h want f", bus.an); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL mid_rst_dp: got %b want 1", bus.dp); end
    checks++; if (bus.frame_start !== 1'b0) begin errors++; $display("FAIL mid_rst_fs: got %b want 0", bus.frame_start); end
    rst = 1'b0;
    tick();
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL mid_restart_fs: got %b want 1", bus.frame_start); end
    checks++; if (bus.seg !== 7'h01) begin errors++; $display("FAIL mid_load_ignored_seg: got %h want 01", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL mid_load_ignored_dp: got %b want 1", bus.dp); end
    tick(GD);
    checks++; if (bus.an !== 4'hE) begin errors++; $display("FAIL mid_restart_an: got %h want e", bus.an); end
    tick(2 * SD - GD);
    checks++; if (bus.seg !== LZ) begin errors++; $display("FAIL mid_shadow_cleared: got %h want %h", bus.seg, LZ); end
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL mid_d2_guard: got %h want f", bus.an); end
  endtask

  task automatic test_blanking();
    test_scan(16'h0040, 4'b1000, {LZ, LZ, 7'h4C, 7'h01});
    test_scan(16'h0000, 4'b0000, {LZ, LZ, LZ, 7'h01});
  endtask

  initial begin
    test_reset();
    test_scan(16'h1A2F, 4'b0100, {7'h4F, 7'h08, 7'h12, 7'h38});
    test_load_on_wrap();
    test_back_to_back();
    test_reset_mid_slot();
    test_blanking();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
